// File: rtl/cpu_prog_harness.sv
// Load/run/dump controller for the single-cycle CPU: streams a program into imem, runs it for a cycle budget, then streams out the register file.
// Optional HALT_DETECT_EN: cpu_halt ends RUN early; when undefined, cpu_halt is ignored.
module cpu_prog_harness #(
  parameter int IW      = 32,
  parameter int IMEM_AW = 10,
  parameter int DW      = 32,
  parameter int NREG    = 32,
  parameter int RAW     = 5,
  parameter int CW      = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CW-1:0]      run_cycles,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [IW-1:0]      ld_data,
  input  logic               ld_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [IW-1:0]      imem_wdata,
  output logic               cpu_rst_n,
  output logic               cpu_stall,
  input  logic               cpu_halt,
  output logic [RAW-1:0]     rf_raddr,
  input  logic [DW-1:0]      rf_rdata,
  output logic               dmp_valid,
  input  logic               dmp_ready,
  output logic [RAW-1:0]     dmp_idx,
  output logic [DW-1:0]      dmp_data,
  output logic               busy,
  output logic               done,
  output logic               ovf
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DUMP = 2'd3;
  localparam logic [IMEM_AW-1:0] WADDR_MAX = '1;
  localparam logic [RAW-1:0]     LAST_REG  = RAW'(NREG - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [IMEM_AW-1:0] waddr_q;
  logic               full_q, ovf_q;
  logic [RAW-1:0]     raddr_q, rd_idx_q, out_idx_q, skid_idx_q;
  logic               iss_done_q, rd_pend_q, out_v_q, skid_v_q;
  logic [DW-1:0]      out_dat_q, skid_dat_q;

  logic       ld_acc, run_end, pop, out_free, iss, fin;
  logic [1:0] held;

  assign ld_acc   = (state_q == S_LOAD) && ld_valid;
  assign pop      = out_v_q && dmp_ready;
  assign out_free = !out_v_q || pop;
  // Words still held after this cycle; a read issued now lands next cycle
  // and must find a free slot even if the consumer stalls.
  assign held     = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_pend_q) - 2'(pop);
  assign iss      = (state_q == S_DUMP) && !iss_done_q && (held <= 2'd1);
  assign fin      = (state_q == S_DUMP) && pop && (out_idx_q == LAST_REG);

`ifdef HALT_DETECT_EN
  assign run_end = (cnt_q == '0) || cpu_halt;
`else
  logic halt_unused;
  assign halt_unused = cpu_halt;
  assign run_end     = (cnt_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)             state_d = S_LOAD;
      S_LOAD:  if (ld_acc && ld_last) state_d = S_RUN;
      S_RUN:   if (run_end)           state_d = S_DUMP;
      S_DUMP:  if (fin)               state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign ld_ready   = (state_q == S_LOAD);
  assign imem_we    = ld_acc && !full_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = imem_we ? ld_data : '0;
  assign cpu_rst_n  = (state_q == S_RUN) || (state_q == S_DUMP);
  assign cpu_stall  = (state_q != S_RUN);
  assign rf_raddr   = raddr_q;
  assign dmp_valid  = out_v_q;
  assign dmp_idx    = out_idx_q;
  assign dmp_data   = out_dat_q;
  assign done       = fin;
  assign ovf        = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      waddr_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      raddr_q    <= '0;
      iss_done_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      out_v_q    <= 1'b0;
      out_idx_q  <= '0;
      out_dat_q  <= '0;
      skid_v_q   <= 1'b0;
      skid_idx_q <= '0;
      skid_dat_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (start) begin
          cnt_q   <= run_cycles;
          waddr_q <= '0;
          full_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        S_LOAD: if (ld_acc) begin
          // Last address stays put once written so overflow words are dropped.
          if (full_q)                    ovf_q   <= 1'b1;
          else if (waddr_q == WADDR_MAX) full_q  <= 1'b1;
          else                           waddr_q <= waddr_q + IMEM_AW'(1);
        end
        S_RUN: if (!run_end) cnt_q <= cnt_q - CW'(1);
        S_DUMP: begin
          if (iss) begin
            if (raddr_q == LAST_REG) iss_done_q <= 1'b1;
            else                     raddr_q    <= raddr_q + RAW'(1);
          end
          rd_pend_q <= iss;
          rd_idx_q  <= raddr_q;
          if (out_free) begin
            if (skid_v_q) begin
              out_v_q    <= 1'b1;
              out_idx_q  <= skid_idx_q;
              out_dat_q  <= skid_dat_q;
              skid_v_q   <= rd_pend_q;
              skid_idx_q <= rd_idx_q;
              skid_dat_q <= rf_rdata;
            end else begin
              out_v_q   <= rd_pend_q;
              out_idx_q <= rd_idx_q;
              out_dat_q <= rf_rdata;
            end
          end else if (rd_pend_q) begin
            skid_v_q   <= 1'b1;
            skid_idx_q <= rd_idx_q;
            skid_dat_q <= rf_rdata;
          end
          if (fin) begin
            raddr_q    <= '0;
            iss_done_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            out_v_q    <= 1'b0;
            out_idx_q  <= '0;
            out_dat_q  <= '0;
            skid_v_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_prog_harness.sv
// Directed bench for cpu_prog_harness: table-driven load vectors plus run/dump/abort sequences (IMEM_AW=2 so overflow is reachable).
module tb_cpu_prog_harness;
  localparam int IW = 32, AW = 2, DW = 32, NREG = 32, RAW = 5, CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0;
  logic [CW-1:0] run_cycles = '0;
  logic ld_valid = 1'b0, ld_last = 1'b0;
  logic [IW-1:0] ld_data = '0;
  logic ld_ready, imem_we, cpu_rst_n, cpu_stall;
  logic [AW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;
  logic cpu_halt = 1'b0;
  logic [RAW-1:0] rf_raddr, dmp_idx;
  logic [DW-1:0] rf_rdata, dmp_data;
  logic dmp_valid, busy, done, ovf;
  logic dmp_ready = 1'b1;

  always #5 clk = ~clk;

  cpu_prog_harness #(.IW(IW), .IMEM_AW(AW), .DW(DW), .NREG(NREG), .RAW(RAW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .run_cycles(run_cycles),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .cpu_stall(cpu_stall), .cpu_halt(cpu_halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dmp_valid(dmp_valid), .dmp_ready(dmp_ready), .dmp_idx(dmp_idx), .dmp_data(dmp_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // Register file model: R[i] = i*3, one-cycle read latency
  logic [DW-1:0] regs [NREG];
  always @(posedge clk) rf_rdata <= regs[rf_raddr];

  typedef struct {
    bit            st;
    logic [CW-1:0] rc;
    bit            v;
    logic [IW-1:0] d;
    bit            last;
    bit            we;
    logic [AW-1:0] a;
    bit            ov;
  } vec_t;
  vec_t tbl [17];

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit st, logic [CW-1:0] rc, bit v, logic [IW-1:0] d,
                              bit last, bit we, logic [AW-1:0] a, bit ov);
    vec_t r;
    r.st = st; r.rc = rc; r.v = v; r.d = d; r.last = last; r.we = we; r.a = a; r.ov = ov;
    return r;
  endfunction

  task automatic do_start(input logic [CW-1:0] rc);
    start = 1'b1; run_cycles = rc;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rstn", cpu_rst_n, 0);
    check("idle_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; run_cycles = '1;
  endtask

  task automatic load_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start = tbl[i].st; run_cycles = tbl[i].rc;
      ld_valid = tbl[i].v; ld_data = tbl[i].d; ld_last = tbl[i].last;
      @(negedge clk);
      check("ld_ready", ld_ready, 1);
      check("load_rstn", cpu_rst_n, 0);
      check("imem_we", imem_we, tbl[i].we);
      if (tbl[i].we) begin
        check("imem_waddr", imem_waddr, tbl[i].a);
        check("imem_wdata", imem_wdata, tbl[i].d);
      end
      check("ovf_load", ovf, tbl[i].ov);
      @(posedge clk); #1;
    end
    start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  // Called at posedge+1 of the first RUN cycle; returns at a negedge.
  task automatic run_dump(input int exp_run, input int halt_at, input int abort_idx);
    int n_run = 0, k = 0, nxt = 0, ndone = 0, bad = 0, stab = 0;
    bit rstn_ok = 1'b1, pst = 1'b0, aborted = 1'b0;
    logic [RAW-1:0] pidx = '0;
    logic [DW-1:0]  pdat = '0;
    cpu_halt = (halt_at == 1);
    @(negedge clk);
    while (!cpu_stall && n_run < 400) begin
      if (!cpu_rst_n) rstn_ok = 1'b0;
      n_run++;
      @(posedge clk); #1;
      cpu_halt = (n_run + 1 == halt_at);
      @(negedge clk);
    end
    cpu_halt = 1'b0;
    check("run_len", n_run, exp_run);
    check("run_rstn", rstn_ok, 1);
    check("dump_entry_rstn", cpu_rst_n, 1);
    dmp_ready = 1'b1;
    while (ndone == 0 && !aborted && k < 400) begin
      if (k == 0 || k == 1) check("dmp_valid_early", dmp_valid, 0);
      if (k == 2) check("dmp_valid_first", dmp_valid, 1);
      if (pst && (dmp_idx !== pidx || dmp_data !== pdat || !dmp_valid)) stab++;
      pst = dmp_valid && !dmp_ready; pidx = dmp_idx; pdat = dmp_data;
      if (dmp_valid && dmp_ready) begin
        if (dmp_idx !== RAW'(nxt) || dmp_data !== DW'(nxt * 3)) bad++;
        nxt++;
      end
      if (done) begin
        ndone++;
        check("done_rstn", cpu_rst_n, 1);
        check("done_idx", dmp_idx, NREG - 1);
      end
      if (abort_idx >= 0 && dmp_valid && dmp_idx == RAW'(abort_idx)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", dmp_valid, 0);
        check("abort_rstn", cpu_rst_n, 0);
        check("abort_stall", cpu_stall, 1);
        rst = 1'b0; aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
        dmp_ready = (abort_idx >= 0) ? 1'b1 : (k % 3 != 2);
        @(negedge clk);
      end
    end
    dmp_ready = 1'b1;
    check("dump_order", bad, 0);
    check("dump_stable", stab, 0);
    if (abort_idx >= 0) begin
      check("abort_reached", aborted, 1);
      check("abort_words", nxt, abort_idx + 1);
    end else begin
      check("dump_count", nxt, NREG);
      check("done_pulses", ndone, 1);
      check("post_done_rstn", cpu_rst_n, 0);
      check("post_done_busy", busy, 0);
      check("post_done_done", done, 0);
      check("post_done_stall", cpu_stall, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = DW'(i * 3);
    // program 1: ld_valid toggling, stray start in LOAD must be ignored
    tbl[0]  = mk(0, 0, 1, 32'hA000_0000, 0, 1, 0, 0);
    tbl[1]  = mk(1, 5, 0, 32'h0,         0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 32'hA000_0001, 0, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 32'hA000_0002, 1, 1, 2, 0);
    // program 2: four back-to-back words, fills imem exactly
    tbl[5]  = mk(0, 0, 1, 32'hB000_0000, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 32'hB000_0001, 0, 1, 1, 0);
    tbl[7]  = mk(0, 0, 1, 32'hB000_0002, 0, 1, 2, 0);
    tbl[8]  = mk(0, 0, 1, 32'hB000_0003, 1, 1, 3, 0);
    // program 3: six words into depth 4, last two dropped
    tbl[9]  = mk(0, 0, 1, 32'hC000_0000, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 1, 32'hC000_0001, 0, 1, 1, 0);
    tbl[11] = mk(0, 0, 1, 32'hC000_0002, 0, 1, 2, 0);
    tbl[12] = mk(0, 0, 1, 32'hC000_0003, 0, 1, 3, 0);
    tbl[13] = mk(0, 0, 1, 32'hC000_0004, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 1, 32'hC000_0005, 1, 0, 0, 1);
    // programs 4/5: single word, ovf cleared by the new start
    tbl[15] = mk(0, 0, 1, 32'hD000_0000, 1, 1, 0, 0);
    tbl[16] = mk(0, 0, 1, 32'hE000_0000, 1, 1, 0, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_cpu_stall", cpu_stall, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_dmp_valid", dmp_valid, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rf_raddr", rf_raddr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_start(9);
    load_rows(0, 4);
    run_dump(10, 0, -1);
    @(posedge clk); #1;

    do_start(0);
    load_rows(5, 8);
    run_dump(1, 0, -1);
    check("ovf_clear", ovf, 0);
    @(posedge clk); #1;

    do_start(3);
    load_rows(9, 14);
    run_dump(4, 0, -1);
    check("ovf_held", ovf, 1);
    @(posedge clk); #1;

    do_start(100);
    load_rows(15, 15);
`ifdef HALT_DETECT_EN
    run_dump(3, 3, 10);
`else
    run_dump(101, 3, 10);
`endif
    @(posedge clk); #1;

    do_start(2);
    load_rows(16, 16);
    run_dump(3, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
